// File: rtl/load_ret_pkg.sv
// Shared definitions for the load return path: funct3 encodings, queue entry
// layout and the alignment/legality rule applied when a load is enqueued.
package load_ret_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Width of the rd field carried in a queue entry; the unit's RD_W must not exceed it.
  localparam int LRU_RD_W = 5;

  typedef struct packed {
    logic [2:0]          funct3;
    logic [1:0]          addr_lo;
    logic [LRU_RD_W-1:0] rd;
    logic                err;
    logic                killed;
  } entry_t;

  function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      LB, LBU: bad = 1'b0;
      LH, LHU: bad = addr_lo[0];
      LW:      bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte/half/word select and sign/zero extension of a returned
// aligned memory word.
module load_extend
  import load_ret_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo_i)
      2'b00:   byte_sel = data_i[7:0];
      2'b01:   byte_sel = data_i[15:8];
      2'b10:   byte_sel = data_i[23:16];
      default: byte_sel = data_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];
  end

  always_comb begin
    result_o = 32'h0;
    case (funct3_i)
      LB:      result_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     result_o = {24'h0, byte_sel};
      LH:      result_o = {{16{half_sel[15]}}, half_sel};
      LHU:     result_o = {16'h0, half_sel};
      LW:      result_o = data_i;
      default: result_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_return_unit.sv
// In-order outstanding-load queue feeding a writeback register stage.
// Define LOAD_RET_BYPASS_EN to let a head result reach wb_* in the same cycle when the stage is empty.
module load_return_unit
  import load_ret_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RD_W  = LRU_RD_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_funct3,
  input  logic [1:0]             req_addr_lo,
  input  logic [RD_W-1:0]        req_rd,
  input  logic                   rsp_valid,
  output logic                   rsp_ready,
  input  logic [31:0]            rsp_data,
  input  logic                   flush,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [31:0]            wb_data,
  output logic [RD_W-1:0]        wb_rd,
  output logic                   wb_err,
  output logic [$clog2(DEPTH):0] outstanding
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready; a
  // producer holding valid keeps its payload stable until the transfer.
  entry_t            q_q [DEPTH];
  entry_t            q_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wb_valid_q, wb_valid_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic              wb_err_q, wb_err_d;

  entry_t      head, new_e;
  logic        head_valid, free, push, pop, deliver, capture;
  logic [31:0] ext_result, res_data;

  assign head       = q_q[rd_ptr_q];
  assign head_valid = (cnt_q != '0);
  assign free       = !wb_valid_q || wb_ready;

  assign req_ready = (cnt_q != CNT_W'(DEPTH));
  assign push      = req_valid && req_ready;

  // A killed entry still owes a memory response, so it drains regardless of the output stage.
  assign rsp_ready = head_valid && !head.err && (head.killed || free);
  assign pop       = head_valid && (head.err ? (head.killed || free) : (rsp_valid && rsp_ready));
  assign deliver   = pop && !head.killed && !flush;

  load_extend u_extend (
    .funct3_i  (head.funct3),
    .addr_lo_i (head.addr_lo),
    .data_i    (rsp_data),
    .result_o  (ext_result)
  );

  assign res_data = head.err ? 32'h0 : ext_result;

`ifdef LOAD_RET_BYPASS_EN
  logic bypass;
  assign bypass   = deliver && !wb_valid_q;
  assign capture  = deliver && !(bypass && wb_ready);
  assign wb_valid = wb_valid_q || bypass;
  assign wb_data  = bypass ? res_data : wb_data_q;
  assign wb_rd    = bypass ? RD_W'(head.rd) : wb_rd_q;
  assign wb_err   = bypass ? head.err : wb_err_q;
`else
  assign capture  = deliver;
  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;
  assign wb_err   = wb_err_q;
`endif

  assign outstanding = cnt_q;

  always_comb begin
    new_e         = '0;
    new_e.funct3  = req_funct3;
    new_e.addr_lo = req_addr_lo;
    new_e.rd      = LRU_RD_W'(req_rd);
    new_e.err     = load_misaligned(req_funct3, req_addr_lo);
    new_e.killed  = 1'b0;
  end

  // Flush is applied after the push so a same-cycle request is killed too.
  always_comb begin
    q_d = q_q;
    if (push) q_d[wr_ptr_q] = new_e;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) q_d[i].killed = 1'b1;
    end
  end

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_err_d   = wb_err_q;
    if (flush) begin
      wb_valid_d = 1'b0;
    end else if (capture) begin
      wb_valid_d = 1'b1;
      wb_data_d  = res_data;
      wb_rd_d    = RD_W'(head.rd);
      wb_err_d   = head.err;
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'h0;
      wb_rd_q    <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      q_q        <= q_d;
      wr_ptr_q   <= wr_ptr_q + PTR_W'(push);
      rd_ptr_q   <= rd_ptr_q + PTR_W'(pop);
      cnt_q      <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_err_q   <= wb_err_d;
    end
  end

endmodule
